// File: rtl/pwm_example_pkg.sv
// Shared constants and types for the pwm_example PWM generator.
// Optional status outputs are enabled by defining PWM_STATUS_EN.
package pwm_example_pkg;

    localparam int PHASE_BITS = 4;
    localparam int DIV_BITS   = 12;
    localparam int PHASE_MAX  = (1 << PHASE_BITS) - 1;

    typedef logic [PHASE_BITS-1:0] phase_t;
    typedef logic [DIV_BITS-1:0]   div_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Step-rate prescaler: emits a one-clock tick every (divider + 1) enabled clocks.
// The divider is live; ">=" lets a smaller value end the current count at once.
module pwm_prescaler
    import pwm_example_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  div_t divider,
    output logic tick
);

    div_t pre_reg;
    div_t pre_next;
    logic wrap;

    always_comb begin
        wrap     = (pre_reg >= divider);
        tick     = ena & wrap;
        pre_next = pre_reg;
        if (ena) begin
            pre_next = wrap ? '0 : pre_reg + div_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

endmodule

// File: rtl/pwm_example.sv
// Tiny-Tapeout style 16-level PWM top: phase counter, period-boundary duty latch, pins.
// Define PWM_STATUS_EN to expose phase and tick on uo_out[4:0].
module pwm_example
    import pwm_example_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // rst_n is active-high despite its name.
    div_t   divider;
    logic   tick;
    logic   pwm;
    phase_t phase_reg;
    phase_t phase_next;
    phase_t duty_q_reg;
    phase_t duty_q_next;

    assign divider = {ui_in, uio_in[3:0]};

    pwm_prescaler u_prescaler (
        .clk     (clk),
        .rst     (rst_n),
        .ena     (ena),
        .divider (divider),
        .tick    (tick)
    );

    // Duty is captured only as the phase wraps, so every period is whole.
    always_comb begin
        phase_next  = phase_reg;
        duty_q_next = duty_q_reg;
        if (tick) begin
            phase_next = phase_reg + phase_t'(1);
            if (phase_reg == phase_t'(PHASE_MAX)) begin
                duty_q_next = uio_in[7:4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            phase_reg  <= '0;
            duty_q_reg <= '0;
        end else begin
            phase_reg  <= phase_next;
            duty_q_reg <= duty_q_next;
        end
    end

    assign pwm = ena & (phase_reg < duty_q_reg);

`ifdef PWM_STATUS_EN
    assign uo_out = {pwm, 2'b00, tick, phase_reg};
`else
    assign uo_out = {pwm, 7'b0};
`endif

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_pwm_example.sv
// Self-checking bench for pwm_example (default build): randomized runs against an
// arithmetic reference derived from clock counts, plus directed boundary steps.
module tb_pwm_example;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    // Reference state: enabled clocks since reset, divider in force, duty latched per period.
    int n_clk;
    int div_v;
    int duty_at [0:255];

    pwm_example dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic [11:0] dv, input logic [3:0] duty);
        ui_in  = dv[11:4];
        uio_in = {duty, dv[3:0]};
        div_v  = int'(dv);
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges, checked, then released just after an edge.
    task automatic do_reset();
        rst_n = 1'b1;
        #1;
        chk("reset_uo_out", uo_out, 8'h00);
        edge_clk();
        chk("reset_hold_uo_out", uo_out, 8'h00);
        rst_n = 1'b0;
        n_clk = 0;
        for (int i = 0; i < 256; i++) duty_at[i] = 0;
    endtask

    // Expected pwm from first principles: step = clocks/(div+1), 16 steps per period.
    function automatic logic expected_pwm();
        int step_i;
        int per_i;
        int ph;
        step_i = n_clk / (div_v + 1);
        per_i  = step_i / 16;
        ph     = step_i % 16;
        return ena && (ph < duty_at[per_i]);
    endfunction

    task automatic run_model(input int cycles, input string tag);
        int d_samp;
        logic en_samp;
        for (int c = 0; c < cycles; c++) begin
            d_samp  = int'(uio_in[7:4]);
            en_samp = ena;
            edge_clk();
            if (en_samp) begin
                n_clk++;
                if (n_clk % (16 * (div_v + 1)) == 0) begin
                    duty_at[n_clk / (16 * (div_v + 1))] = d_samp;
                end
            end
            chk(tag, uo_out, {expected_pwm(), 7'b0});
            chk({tag, "_uio_out"}, uio_out, 8'h00);
            chk({tag, "_uio_oe"}, uio_oe, 8'h00);
        end
    endtask

    initial begin
        int cnt;
        int d_r;
        int duty_r;
        rst_n = 1'b1;
        ena   = 1'b1;
        set_in(12'd0, 4'd8);

        // Divider 0, duty 8: 16 low clocks, then 8 high / 8 low.
        do_reset();
        run_model(64, "div0_duty8");

        // Divider 3, duty 4: 64-clock periods with 16 high clocks.
        set_in(12'd3, 4'd4);
        do_reset();
        run_model(3 * 64, "div3_duty4");

        // Duty extremes at divider 0.
        set_in(12'd0, 4'd0);
        do_reset();
        run_model(48, "duty0");
        set_in(12'd0, 4'd15);
        do_reset();
        run_model(48, "duty15");

        // Duty 4 -> 12 mid-period takes effect only at the next boundary.
        set_in(12'd0, 4'd4);
        do_reset();
        run_model(18, "duty_chg_a");
        set_in(12'd0, 4'd12);
        run_model(46, "duty_chg_b");

        // ena low for 10 clocks during the high phase stretches the period.
        set_in(12'd0, 4'd8);
        do_reset();
        run_model(19, "ena_pre");
        ena = 1'b0;
        run_model(10, "ena_low");
        ena = 1'b1;
        run_model(40, "ena_resume");

        // Asynchronous reset in mid-period clears outputs before any edge.
        set_in(12'd2, 4'd10);
        do_reset();
        run_model(60, "pre_midreset");
        do_reset();
        run_model(60, "post_midreset");

        // Randomized divider/duty with a random mid-run duty change.
        for (int r = 0; r < 6; r++) begin
            d_r    = $urandom_range(0, 5);
            duty_r = $urandom_range(0, 15);
            set_in(12'(d_r), 4'(duty_r));
            do_reset();
            run_model($urandom_range(20, 150), "rand_a");
            uio_in[7:4] = 4'($urandom_range(0, 15));
            run_model(2 * 16 * (d_r + 1), "rand_b");
        end

        // Divider lowered 0xFFF -> 0x001 while the prescaler count is large.
        set_in(12'd0, 4'd1);
        do_reset();
        repeat (16) edge_clk();
        chk("divdrop_start", uo_out, 8'h80);
        set_in(12'hFFF, 4'd1);
        repeat (3000) edge_clk();
        chk("divdrop_hold", uo_out, 8'h80);
        set_in(12'h001, 4'd1);
        edge_clk();
        chk("divdrop_immediate_tick", uo_out, 8'h00);
        cnt = 0;
        while (uo_out[7] !== 1'b1 && cnt < 100) begin
            edge_clk();
            cnt++;
        end
        chk_int("divdrop_rise_clocks", cnt, 30);
        while (uo_out[7] !== 1'b0 && cnt < 100) begin
            edge_clk();
            cnt++;
        end
        chk_int("divdrop_period_clocks", cnt, 32);
        chk("divdrop_uio_out", uio_out, 8'h00);
        chk("divdrop_uio_oe", uio_oe, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
